reg_bank: RTL and testbench

//  Parametrised bank of DEPTH words x WIDTH bits built from flops: the next generation of the 1/16-bit registers.

---
 rtl/reg_bank.sv | 107 ++++++++++
 tb/tb_reg_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// DEPTH x WIDTH flop-based register bank: one write port, registered read with valid strobe, clear sequencer.
// Define RAM_BYPASS_EN to forward same-edge write data to a read of the same address.
module reg_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       cnt_reg, cnt_next;
  logic [DEPTH-1:0][WIDTH-1:0] mem_flat;
  logic [WIDTH-1:0]        rd_data_reg, rd_data_next, rd_word;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    idle, wr_ok, rd_ok, rd_in_range;

  assign idle        = (state_reg == IDLE);
  assign wr_ok       = idle && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign rd_ok       = idle && rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The counter parks at the last word rather than wrapping; it is rewound when a clear starts.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST) state_next = IDLE;
        else                 cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic [WIDTH-1:0] word_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                 word_reg <= '0;
        else if (state_reg == CLEAR && cnt_reg == IDX) word_reg <= '0;
        else if (wr_ok && wr_addr == IDX)             word_reg <= wr_data;
      end

      assign mem_flat[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_flat[rd_addr];
`ifdef RAM_BYPASS_EN
    if (rd_in_range && wr_ok && wr_addr == rd_addr) rd_word = wr_data;
`endif
    rd_data_next  = rd_ok ? rd_word : rd_data_reg;
    rd_valid_next = rd_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == CLEAR);

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a 16-word instance with a reference model and a 12-word instance for range checks.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en, clr_req, rd_valid, busy;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic        b_wr_en, b_rd_en, b_clr_req, b_rd_valid, b_busy;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [15:0] b_wr_data, b_rd_data;

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .busy(busy)
  );

  reg_bank #(.WIDTH(16), .DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .clr_req(b_clr_req), .busy(b_busy)
  );

  int          tests = 0;
  int          fails = 0;
  int          busy_left = 0;
  int          busy_cnt;
  logic [15:0] model  [16];
  logic [15:0] bmodel [12];
  logic [15:0] exp_q [$];
  logic [15:0] b_q   [$];
  logic [15:0] last_rd, b_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_left = 0;
    exp_q.delete();
    b_q.delete();
    last_rd = 16'h0;
    b_last  = 16'h0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    for (int i = 0; i < 12; i++) bmodel[i] = 16'h0;
  endtask

  // One cycle on the 16-word instance: drive at negedge, check #1 after the following posedge.
  task automatic cyc(input bit we, input int wa, input logic [15:0] wd,
                     input bit re, input int ra, input bit clr);
    logic [15:0] e;
    bit          acc;
    @(negedge clk);
    wr_en = we; wr_addr = wa[3:0]; wr_data = wd;
    rd_en = re; rd_addr = ra[3:0]; clr_req = clr;
    acc = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (re) begin
        e = model[ra];
`ifdef RAM_BYPASS_EN
        if (we && wa == ra) e = wd;
`endif
        exp_q.push_back(e);
        acc = 1'b1;
      end
      if (we) model[wa] = wd;
      if (clr) begin
        busy_left = 16;
        for (int i = 0; i < 16; i++) model[i] = 16'h0;
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {31'h0, rd_valid}, {31'h0, acc});
    if (rd_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_data", {16'h0, rd_data}, {16'h0, e});
      last_rd = e;
    end else begin
      chk("rd_hold", {16'h0, rd_data}, {16'h0, last_rd});
    end
    chk("busy", {31'h0, busy}, {31'h0, (busy_left > 0)});
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 0, 16'h0, 1'b0, 0, 1'b0);
  endtask

  // One cycle on the 12-word instance.
  task automatic bcyc(input bit we, input int wa, input logic [15:0] wd, input bit re, input int ra);
    logic [15:0] e;
    @(negedge clk);
    b_wr_en = we; b_wr_addr = wa[3:0]; b_wr_data = wd;
    b_rd_en = re; b_rd_addr = ra[3:0]; b_clr_req = 1'b0;
    if (re) begin
      e = (ra < 12) ? bmodel[ra] : 16'h0;
`ifdef RAM_BYPASS_EN
      if (we && wa == ra && wa < 12) e = wd;
`endif
      b_q.push_back(e);
    end
    if (we && wa < 12) bmodel[wa] = wd;
    @(posedge clk);
    #1;
    chk("b_rd_valid", {31'h0, b_rd_valid}, {31'h0, re});
    if (b_rd_valid === 1'b1 && b_q.size() > 0) begin
      e = b_q.pop_front();
      chk("b_rd_data", {16'h0, b_rd_data}, {16'h0, e});
      b_last = e;
    end else begin
      chk("b_rd_hold", {16'h0, b_rd_data}, {16'h0, b_last});
    end
    chk("b_busy", {31'h0, b_busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; clr_req = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rd_en = 0; b_rd_addr = 0; b_clr_req = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_rd_data", {16'h0, rd_data}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_b_rd_data", {16'h0, b_rd_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Read after reset, single-cycle valid
    cyc(1'b0, 0, 16'h0, 1'b1, 3, 1'b0);
    idle_cyc();
    idle_cyc();

    // Write then read back
    cyc(1'b1, 5, 16'hBEEF, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 16'h0, 1'b1, 5, 1'b0);
    idle_cyc();

    // Same-edge write and read to one address
    cyc(1'b1, 5, 16'h1234, 1'b1, 5, 1'b0);
    idle_cyc();
    cyc(1'b0, 0, 16'h0, 1'b1, 5, 1'b0);
    cyc(1'b1, 9, 16'h0F0F, 1'b1, 5, 1'b0);
    cyc(1'b0, 0, 16'h0, 1'b1, 9, 1'b0);

    // Fill, then clear together with a write and a read on the same edge
    for (int i = 0; i < 16; i++) cyc(1'b1, i, 16'hA5A5, 1'b0, 0, 1'b0);
    cyc(1'b1, 7, 16'h1111, 1'b1, 5, 1'b1);
    busy_cnt = 1;
    for (int j = 0; j < 20; j++) begin
      if (busy_left > 0) cyc(1'b1, j % 16, 16'hFFFF, 1'b1, j % 16, j == 8);
      else idle_cyc();
      if (busy === 1'b1) busy_cnt++;
    end
    chk("busy_len", busy_cnt, 16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0);
    idle_cyc();

    // Asynchronous reset in the middle of a clear
    for (int i = 0; i < 16; i++) cyc(1'b1, i, 16'h5A5A, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 16'h0, 1'b1, 2, 1'b1);
    for (int j = 0; j < 6; j++) idle_cyc();
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_req = 0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("mid_rst_rd_data", {16'h0, rd_data}, 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 16'h0, 1'b1, i, 1'b0);
    cyc(1'b1, 3, 16'h4242, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 16'h0, 1'b1, 3, 1'b0);
    idle_cyc();

    // DEPTH=12 instance: out-of-range writes ignored, out-of-range reads return zero
    for (int i = 0; i < 12; i++) bcyc(1'b1, i, 16'(i * 16'h1111 + 1), 1'b0, 0);
    bcyc(1'b1, 13, 16'hFFFF, 1'b0, 0);
    bcyc(1'b1, 12, 16'hFFFF, 1'b1, 11);
    bcyc(1'b0, 0, 16'h0, 1'b1, 13);
    bcyc(1'b0, 0, 16'h0, 1'b1, 12);
    bcyc(1'b1, 15, 16'hEEEE, 1'b1, 15);
    for (int i = 0; i < 12; i++) bcyc(1'b0, 0, 16'h0, 1'b1, i);
    bcyc(1'b0, 0, 16'h0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
